uart_rx: RTL
============

# uart_rx

Serial-to-parallel receive half of the UART. It recovers 8N1 or 8E1 frames from the asynchronous RX line, sampling each bit at its centre with a per-bit clock counter. It presents each received byte with a one-cycle validity strobe and frame-error flags, and pairs with the transmit path inside UART_TOP for loopback and external links.

## Interface
Parameters:
- CLKS_PER_BIT, 5208: CLK cycles per bit (50 MHz / 9600 baud). Legal values are ≥ 4. HALF_BIT = CLKS_PER_BIT/2, integer division.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- RX_IN  in  1  asynchronous serial line; idle high.
- par_EN  in  1  1 = a parity bit follows the data (even parity); 0 = no parity bit.
- RXDATA  out  8  last received byte, LSB received first.
- VALID_RX  out  1  one-cycle strobe: frame complete with no error.
- PARITY_ERROR  out  1  one-cycle strobe: parity mismatch.
- STOP_ERROR  out  1  one-cycle strobe: stop bit sampled low.
- busy  out  1  high from start detection until the frame ends or is aborted.

## Operation
- RX_IN passes through a 2-FF synchronizer; the output is rx_s. Both flops reset to 1. All decisions use rx_s only.
- FSM states are IDLE, START, DATA, PARITY, STOP. A counter cnt (width clog2(CLKS_PER_BIT)) and a bit index idx[2:0] support it.
- IDLE:
  - If armed=1 and rx_s=0: go to START, cnt=0, latch par_EN into par_q.
  - armed is set whenever rx_s=1 in IDLE, and cleared on entering START.
- START: cnt increments each cycle. At cnt==HALF_BIT-1, sample rx_s:
  - rx_s=0: go to DATA, cnt=0, idx=0.
  - rx_s=1: glitch. Return to IDLE with no strobes.
- DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into shreg[idx], cnt=0.
  - After idx=7: go to PARITY if par_q=1, else go to STOP.
- PARITY: at cnt==CLKS_PER_BIT-1, store the sampled bit p, cnt=0, go to STOP. A parity error exists when p != ^shreg (even parity).
- STOP: at cnt==CLKS_PER_BIT-1, sample the stop bit, then go to IDLE at mid-stop-bit. This re-arms the receiver half a bit early.
- Frame completion, registered on the next edge:
  - RXDATA <= shreg. This update happens on every completed frame, including erroneous ones, and the value holds until the next completion.
  - PARITY_ERROR pulses if par_q=1 and a parity mismatch occurred.
  - STOP_ERROR pulses if the stop bit was 0.
  - VALID_RX pulses if neither error occurred. It is mutually exclusive with both error strobes; the two error strobes may assert together.
- Break or held-low line: after a STOP_ERROR with rx_s still 0, armed stays 0. No new frame starts until rx_s has been high for ≥1 cycle.
- A par_EN change mid-frame has no effect; the frame uses par_q.

## Timing
- Reset values: RXDATA=0x00; VALID_RX=PARITY_ERROR=STOP_ERROR=busy=0; FSM=IDLE; cnt=0; idx=0; armed=0; synchronizer flops=1.
- RST asserted mid-frame aborts the frame on the next edge. No strobes are issued and RXDATA is cleared.
- Start detect: an RX_IN falling edge appears on rx_s after 2 edges. IDLE→START happens on the following edge, and busy rises with the START entry.
- Sample points relative to START entry:
  - Start bit: HALF_BIT cycles.
  - Data bit n (n = 0..7): HALF_BIT + (n+1)·CLKS_PER_BIT cycles.
  - Parity bit: HALF_BIT + 9·CLKS_PER_BIT cycles.
  - Stop bit: HALF_BIT + (9+par_q)·CLKS_PER_BIT cycles.
- Strobes assert exactly 1 cycle after the stop sample, for 1 cycle. busy falls on the same edge.
- Tolerates up to ±HALF_BIT/ (10+par_q) cycles of cumulative baud error per frame.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- par_EN=1; send 0x6F with parity bit 0 and stop 1 → RXDATA=0x6F, a single VALID_RX pulse, both error flags 0, busy low afterwards.
- par_EN=1; send 0x6F with parity bit 1 → PARITY_ERROR pulse, VALID_RX stays 0, RXDATA=0x6F.
- par_EN=0; send 0xA5 with stop bit 0, then hold RX_IN low for 40 cycles and release → one STOP_ERROR pulse, RXDATA=0xA5, busy stays low until RX_IN returns high, no second frame.
- RX_IN low for 4 cycles while idle → busy pulses for HALF_BIT cycles, no strobes, RXDATA unchanged.
- par_EN=0; back-to-back frames 0x00 then 0xFF with no idle gap → two VALID_RX pulses with RXDATA 0x00 then 0xFF.
- RST high for 1 cycle during data bit 3 → all outputs 0 on the next edge; a following clean 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1/8E1 serial receiver with centre-of-bit sampling.
// Presents each byte with a one-cycle strobe and frame-error flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       par_EN,
    output logic [7:0] RXDATA,
    output logic       VALID_RX,
    output logic       PARITY_ERROR,
    output logic       STOP_ERROR,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HLAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    idx, idx_nx;
    logic          armed, armed_nx;
    logic          rx_m, rx_s;
    logic          par_q;
    logic [7:0]    shreg;
    logic          p_err;
    logic          stop_bit;
    logic          done;
    logic          start_go, sh_en, par_smp, stop_smp;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CW'(1);
        idx_nx   = idx;
        armed_nx = armed;
        start_go = 1'b0;
        sh_en    = 1'b0;
        par_smp  = 1'b0;
        stop_smp = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (rx_s) begin
                    armed_nx = 1'b1;
                end else if (armed) begin
                    state_nx = START;
                    armed_nx = 1'b0;
                    start_go = 1'b1;
                end
            end
            START: begin
                if (cnt == HLAST) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    // A line back high at mid-start is a glitch, not a frame
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_nx = '0;
                    sh_en  = 1'b1;
                    idx_nx = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nx = par_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt == LAST) begin
                    cnt_nx   = '0;
                    par_smp  = 1'b1;
                    state_nx = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop so the next start edge is not missed
                if (cnt == LAST) begin
                    cnt_nx   = '0;
                    stop_smp = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_m         <= 1'b1;
            rx_s         <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            armed        <= 1'b0;
            par_q        <= 1'b0;
            shreg        <= '0;
            p_err        <= 1'b0;
            stop_bit     <= 1'b1;
            done         <= 1'b0;
            RXDATA       <= '0;
            VALID_RX     <= 1'b0;
            PARITY_ERROR <= 1'b0;
            STOP_ERROR   <= 1'b0;
        end else begin
            rx_m         <= RX_IN;
            rx_s         <= rx_m;
            state        <= state_nx;
            cnt          <= cnt_nx;
            idx          <= idx_nx;
            armed        <= armed_nx;
            done         <= stop_smp;
            VALID_RX     <= 1'b0;
            PARITY_ERROR <= 1'b0;
            STOP_ERROR   <= 1'b0;
            if (start_go) begin
                par_q <= par_EN;
                p_err <= 1'b0;
            end
            if (sh_en) begin
                shreg[idx] <= rx_s;
            end
            if (par_smp) begin
                p_err <= rx_s ^ (^shreg);
            end
            if (stop_smp) begin
                stop_bit <= rx_s;
            end
            if (done) begin
                RXDATA       <= shreg;
                PARITY_ERROR <= par_q & p_err;
                STOP_ERROR   <= ~stop_bit;
                VALID_RX     <= ~(par_q & p_err) & stop_bit;
            end
        end
    end

    // Held through the completion cycle so it falls with the strobes
    assign busy = (state != IDLE) | done;

endmodule
